// File: rtl/alu_issue_scheduler.sv
// Dual-issue in-order scheduler: 2-slot instruction buffer plus per-register scoreboard
// feeding ALU pipe0/pipe1 with RAW/WAW-safe issue and branch-flush squashing.
module alu_issue_scheduler #(
    parameter int unsigned WB_LAT = 2,
    parameter int unsigned CNT_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    input  logic [4:0]  in_dst0,
    input  logic [4:0]  in_dst1,
    input  logic        in_wr0,
    input  logic        in_wr1,
    input  logic        in_usert0,
    input  logic        in_usert1,
    input  logic        flush,
    output logic        iss0_valid,
    output logic [31:0] iss0_instr,
    output logic [31:0] iss0_pc,
    output logic        iss1_valid,
    output logic [31:0] iss1_instr,
    output logic [31:0] iss1_pc,
    output logic [31:0] issue_cnt
);

    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PAIR,
        ST_S0,
        ST_S1
    } state_t;

    state_t         r_state;
    logic [31:0]    r_instr0, r_instr1;
    logic [31:0]    r_pc0, r_pc1;
    logic [RW-1:0]  r_dst0, r_dst1;
    logic           r_wr0, r_wr1;
    logic           r_usert0, r_usert1;
    logic [CNT_W-1:0] r_sb [NREG];
    logic [31:0]    r_issue_cnt;

    logic [NREG-1:0] w_busy;
    logic [RW-1:0]  w_rs0, w_rt0, w_rs1, w_rt1;
    logic           w_ok0, w_ok1, w_dep;
    logic           w_iss0, w_iss1, w_p0_sel1, w_drain;
    logic           w_p0_wr, w_p1_wr;
    logic [RW-1:0]  w_p0_dst;
    logic           w_accept;

    // Register r is busy while its writeback is still in flight; r0 is never busy
    always_comb begin
        w_busy = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_busy[i] = (r_sb[i] != '0) && (i != 0);
        end
    end

    assign w_rs0 = r_instr0[25:21];
    assign w_rt0 = r_instr0[20:16];
    assign w_rs1 = r_instr1[25:21];
    assign w_rt1 = r_instr1[20:16];

    assign w_ok0 = !w_busy[w_rs0] && !(r_usert0 && w_busy[w_rt0]) && !(r_wr0 && w_busy[r_dst0]);
    assign w_ok1 = !w_busy[w_rs1] && !(r_usert1 && w_busy[w_rt1]) && !(r_wr1 && w_busy[r_dst1]);

    // Younger slot depends on the older one within the pair (RAW or WAW)
    assign w_dep = r_wr0 && (r_dst0 != '0) &&
                   ((r_dst0 == w_rs1) || (r_usert1 && (r_dst0 == w_rt1)) ||
                    (r_wr1 && (r_dst0 == r_dst1)));

    // Issue decision; the oldest pending instruction always goes to pipe0
    always_comb begin
        w_iss0    = 1'b0;
        w_iss1    = 1'b0;
        w_p0_sel1 = 1'b0;
        w_drain   = 1'b0;
        case (r_state)
            ST_EMPTY: w_drain = 1'b1;
            ST_PAIR: begin
                w_iss0  = w_ok0;
                w_iss1  = w_ok0 && w_ok1 && !w_dep;
                w_drain = w_ok0 && w_ok1 && !w_dep;
            end
            ST_S0: begin
                w_iss0  = w_ok0;
                w_drain = w_ok0;
            end
            ST_S1: begin
                w_iss0    = w_ok1;
                w_p0_sel1 = 1'b1;
                w_drain   = w_ok1;
            end
            default: w_drain = 1'b0;
        endcase
        if (flush) begin
            w_iss0  = 1'b0;
            w_iss1  = 1'b0;
            w_drain = 1'b0;
        end
    end

    assign iss0_valid = w_iss0;
    assign iss0_instr = w_p0_sel1 ? r_instr1 : r_instr0;
    assign iss0_pc    = w_p0_sel1 ? r_pc1 : r_pc0;
    assign iss1_valid = w_iss1;
    assign iss1_instr = r_instr1;
    assign iss1_pc    = r_pc1;
    assign issue_cnt  = r_issue_cnt;

    assign in_ready = !flush && w_drain;
    assign w_accept = in_ready && (in_valid != 2'b00);

    assign w_p0_wr  = w_iss0 && (w_p0_sel1 ? r_wr1 : r_wr0);
    assign w_p0_dst = w_p0_sel1 ? r_dst1 : r_dst0;
    assign w_p1_wr  = w_iss1 && r_wr1;

    // Buffer FSM: reload and drain share an edge so back-to-back pairs see no bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_instr0 <= '0;
            r_instr1 <= '0;
            r_pc0    <= '0;
            r_pc1    <= '0;
            r_dst0   <= '0;
            r_dst1   <= '0;
            r_wr0    <= 1'b0;
            r_wr1    <= 1'b0;
            r_usert0 <= 1'b0;
            r_usert1 <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_instr0 <= in_instr0;
            r_instr1 <= in_instr1;
            r_pc0    <= in_pc0;
            r_pc1    <= in_pc1;
            r_dst0   <= in_dst0;
            r_dst1   <= in_dst1;
            r_wr0    <= in_wr0;
            r_wr1    <= in_wr1;
            r_usert0 <= in_usert0;
            r_usert1 <= in_usert1;
            case (in_valid)
                2'b01:   r_state <= ST_S0;
                2'b10:   r_state <= ST_S1;
                default: r_state <= ST_PAIR;
            endcase
        end else if (w_drain) begin
            r_state <= ST_EMPTY;
        end else if ((r_state == ST_PAIR) && w_iss0) begin
            r_state <= ST_S1;
        end
    end

    // Scoreboard: a new issue reloads the counter, otherwise it counts down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if ((i != 0) && ((w_p0_wr && (w_p0_dst == RW'(i))) ||
                                 (w_p1_wr && (r_dst1 == RW'(i))))) begin
                    r_sb[i] <= CNT_W'(WB_LAT);
                end else if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
        end else begin
            r_issue_cnt <= r_issue_cnt + 32'(w_iss0) + 32'(w_iss1);
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler (WB_LAT=2): dual issue, intra-pair and
// scoreboard RAW stalls, flush, async reset, single-slot issue and counter wrap.
module tb_alu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [31:0] in_instr0, in_instr1, in_pc0, in_pc1;
    logic [4:0]  in_dst0, in_dst1;
    logic        in_wr0, in_wr1, in_usert0, in_usert1;
    logic        flush;
    logic        iss0_valid, iss1_valid;
    logic [31:0] iss0_instr, iss0_pc, iss1_instr, iss1_pc;
    logic [31:0] issue_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt;

    alu_issue_scheduler dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_dst0(in_dst0), .in_dst1(in_dst1),
        .in_wr0(in_wr0), .in_wr1(in_wr1),
        .in_usert0(in_usert0), .in_usert1(in_usert1),
        .flush(flush),
        .iss0_valid(iss0_valid), .iss0_instr(iss0_instr), .iss0_pc(iss0_pc),
        .iss1_valid(iss1_valid), .iss1_instr(iss1_instr), .iss1_pc(iss1_pc),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'h0020};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] d,
                        input logic wr, input logic ur);
        in_instr0 = ins; in_pc0 = pc; in_dst0 = d; in_wr0 = wr; in_usert0 = ur;
    endtask

    task automatic set1(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] d,
                        input logic wr, input logic ur);
        in_instr1 = ins; in_pc1 = pc; in_dst1 = d; in_wr1 = wr; in_usert1 = ur;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 2'b00;
        set0(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set1(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Reset values
        @(negedge clk); #1;
        chk1("rst_iss0", iss0_valid, 1'b0);
        chk1("rst_iss1", iss1_valid, 1'b0);
        chk("rst_cnt", issue_cnt, 32'h0);
        chk1("rst_ready", in_ready, 1'b1);
        @(negedge clk); rst = 1'b0;

        // Independent pairs back to back: dual issue each cycle, no bubble
        exp_cnt = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                set0(mk(5'd10, 5'd11), 32'h100 + 32'(16 * k), 5'(1 + 2 * k), 1'b1, 1'b1);
                set1(mk(5'd12, 5'd13), 32'h104 + 32'(16 * k), 5'(2 + 2 * k), 1'b1, 1'b1);
                in_valid = 2'b11;
            end else begin
                in_valid = 2'b00;
            end
            #1;
            chk1("ind_ready", in_ready, 1'b1);
            if (k > 0) begin
                chk1("ind_iss0", iss0_valid, 1'b1);
                chk1("ind_iss1", iss1_valid, 1'b1);
                chk("ind_pc0", iss0_pc, 32'h100 + 32'(16 * (k - 1)));
                chk("ind_pc1", iss1_pc, 32'h104 + 32'(16 * (k - 1)));
                chk("ind_cnt", issue_cnt, exp_cnt);
                exp_cnt = exp_cnt + 32'd2;
            end
        end

        // Intra-pair RAW on r8: slot0 now, slot1 on pipe0 WB_LAT+1 cycles later
        @(negedge clk);
        set0(mk(5'd10, 5'd11), 32'h200, 5'd8, 1'b1, 1'b1);
        set1(mk(5'd8, 5'd12), 32'h204, 5'd9, 1'b1, 1'b1);
        in_valid = 2'b11; #1;
        chk("raw_cnt0", issue_cnt, exp_cnt);
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("raw_n_iss0", iss0_valid, 1'b1);
        chk("raw_n_pc0", iss0_pc, 32'h200);
        chk1("raw_n_iss1", iss1_valid, 1'b0);
        chk1("raw_n_ready", in_ready, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk1("raw_wait_iss0", iss0_valid, 1'b0);
            chk1("raw_wait_ready", in_ready, 1'b0);
        end
        @(negedge clk); #1;
        chk1("raw_go_iss0", iss0_valid, 1'b1);
        chk("raw_go_pc0", iss0_pc, 32'h204);
        chk("raw_go_instr0", iss0_instr, mk(5'd8, 5'd12));
        chk1("raw_go_iss1", iss1_valid, 1'b0);
        chk1("raw_go_ready", in_ready, 1'b1);
        chk("raw_go_cnt", issue_cnt, exp_cnt);
        exp_cnt = exp_cnt + 32'd1;

        // Scoreboard RAW on r5; r0 as source/destination never stalls
        @(negedge clk);
        set0(mk(5'd10, 5'd11), 32'h300, 5'd5, 1'b1, 1'b0);
        in_valid = 2'b01; #1;
        @(negedge clk);
        set0(mk(5'd5, 5'd0), 32'h310, 5'd0, 1'b1, 1'b1);
        set1(mk(5'd0, 5'd0), 32'h314, 5'd0, 1'b1, 1'b1);
        in_valid = 2'b11; #1;
        chk1("sb_w_iss0", iss0_valid, 1'b1);
        chk("sb_w_pc0", iss0_pc, 32'h300);
        chk1("sb_w_ready", in_ready, 1'b1);
        exp_cnt = exp_cnt + 32'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); in_valid = 2'b00; #1;
            chk1("sb_stall_iss0", iss0_valid, 1'b0);
            chk1("sb_stall_iss1", iss1_valid, 1'b0);
        end
        @(negedge clk); #1;
        chk1("sb_go_iss0", iss0_valid, 1'b1);
        chk1("sb_go_iss1", iss1_valid, 1'b1);
        chk("sb_go_pc0", iss0_pc, 32'h310);
        chk("sb_go_pc1", iss1_pc, 32'h314);
        chk("sb_go_cnt", issue_cnt, exp_cnt);
        exp_cnt = exp_cnt + 32'd2;

        // Flush while a pair is stalled on r7; scoreboard keeps counting through it
        @(negedge clk);
        set0(mk(5'd10, 5'd11), 32'h400, 5'd7, 1'b1, 1'b0);
        in_valid = 2'b01; #1;
        @(negedge clk);
        set0(mk(5'd7, 5'd11), 32'h410, 5'd14, 1'b1, 1'b0);
        set1(mk(5'd12, 5'd13), 32'h414, 5'd15, 1'b1, 1'b1);
        in_valid = 2'b11; #1;
        chk1("fl_w_iss0", iss0_valid, 1'b1);
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk); in_valid = 2'b00; flush = 1'b1; #1;
        chk1("fl_iss0", iss0_valid, 1'b0);
        chk1("fl_iss1", iss1_valid, 1'b0);
        chk1("fl_ready", in_ready, 1'b0);
        @(negedge clk); flush = 1'b0;
        set0(mk(5'd7, 5'd0), 32'h420, 5'd16, 1'b1, 1'b0);
        in_valid = 2'b01; #1;
        chk1("fl_after_ready", in_ready, 1'b1);
        chk1("fl_after_iss0", iss0_valid, 1'b0);
        chk("fl_after_cnt", issue_cnt, exp_cnt);
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("fl_r7_free_iss0", iss0_valid, 1'b1);
        chk("fl_r7_free_pc0", iss0_pc, 32'h420);
        exp_cnt = exp_cnt + 32'd1;
        // Flush squashes an otherwise issuable slot
        @(negedge clk);
        set0(mk(5'd10, 5'd11), 32'h430, 5'd17, 1'b1, 1'b0);
        in_valid = 2'b01; #1;
        @(negedge clk); in_valid = 2'b00; flush = 1'b1; #1;
        chk1("fl_sq_iss0", iss0_valid, 1'b0);
        chk1("fl_sq_ready", in_ready, 1'b0);
        @(negedge clk); flush = 1'b0; #1;
        chk1("fl_sq_after_iss0", iss0_valid, 1'b0);
        chk1("fl_sq_after_ready", in_ready, 1'b1);
        chk("fl_sq_cnt", issue_cnt, exp_cnt);

        // Async reset while in S1 with r21 busy
        @(negedge clk);
        set0(mk(5'd10, 5'd11), 32'h500, 5'd21, 1'b1, 1'b0);
        set1(mk(5'd21, 5'd0), 32'h504, 5'd22, 1'b1, 1'b0);
        in_valid = 2'b11; #1;
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("ar_iss0", iss0_valid, 1'b1);
        chk("ar_pc0", iss0_pc, 32'h500);
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk); #1;
        chk("ar_cnt_pre", issue_cnt, exp_cnt);
        rst = 1'b1; #1;
        chk1("ar_iss0_rst", iss0_valid, 1'b0);
        chk1("ar_iss1_rst", iss1_valid, 1'b0);
        chk("ar_cnt_rst", issue_cnt, 32'h0);
        chk1("ar_ready_rst", in_ready, 1'b1);
        exp_cnt = 32'h0;
        @(negedge clk); rst = 1'b0;
        set0(mk(5'd21, 5'd22), 32'h510, 5'd23, 1'b1, 1'b1);
        set1(mk(5'd22, 5'd0), 32'h514, 5'd24, 1'b1, 1'b0);
        in_valid = 2'b11; #1;
        chk1("ar_rel_ready", in_ready, 1'b1);
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("ar_rel_iss0", iss0_valid, 1'b1);
        chk1("ar_rel_iss1", iss1_valid, 1'b1);
        chk("ar_rel_pc0", iss0_pc, 32'h510);
        chk("ar_rel_cnt", issue_cnt, exp_cnt);
        exp_cnt = exp_cnt + 32'd2;

        // Younger slot only: issues on pipe0
        @(negedge clk);
        set0(mk(5'd0, 5'd0), 32'h0000_BAD0, 5'd25, 1'b1, 1'b0);
        set1(mk(5'd10, 5'd0), 32'h600, 5'd26, 1'b1, 1'b0);
        in_valid = 2'b10; #1;
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("s1_iss0", iss0_valid, 1'b1);
        chk("s1_pc0", iss0_pc, 32'h600);
        chk("s1_instr0", iss0_instr, mk(5'd10, 5'd0));
        chk1("s1_iss1", iss1_valid, 1'b0);
        chk("s1_cnt", issue_cnt, exp_cnt);

        // Counter wrap: preload all-ones, one dual issue lands on 1
        @(negedge clk);
        force dut.r_issue_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_issue_cnt;
        #1;
        chk("wrap_pre", issue_cnt, 32'hFFFF_FFFF);
        set0(mk(5'd10, 5'd11), 32'h700, 5'd27, 1'b1, 1'b1);
        set1(mk(5'd12, 5'd13), 32'h704, 5'd28, 1'b1, 1'b1);
        in_valid = 2'b11;
        @(negedge clk); in_valid = 2'b00; #1;
        chk1("wrap_iss0", iss0_valid, 1'b1);
        chk1("wrap_iss1", iss1_valid, 1'b1);
        chk("wrap_cnt_hold", issue_cnt, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("wrap_cnt", issue_cnt, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
